// File: rtl/md_scheduler_pkg.sv
// Shared types and constants for the multiply/divide scheduler.
package md_scheduler_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned OP_W            = 3;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 4;

    typedef enum logic [OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } md_res_t;

endpackage

// File: rtl/md_scheduler_if.sv
// Stage-E side bundle of the MD unit: request, operands, status and HI/LO view.
interface md_scheduler_if;
    import md_scheduler_pkg::*;

    logic              Start;
    logic [OP_W-1:0]   MDOp;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              MDInD;
    logic              Busy;
    logic              MDStall;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;
    logic [DATA_W-1:0] MDRes;

    modport master (
        output Start, MDOp, A, B, MDInD,
        input  Busy, MDStall, HI, LO, MDRes
    );

    modport slave (
        input  Start, MDOp, A, B, MDInD,
        output Busy, MDStall, HI, LO, MDRes
    );

endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath; hi/lo carry product halves or remainder/quotient.
module md_calc
    import md_scheduler_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  md_op_t            mdop,
    output md_res_t           res,
    output logic              dz
);

    logic signed [2*DATA_W-1:0] sa;
    logic signed [2*DATA_W-1:0] sb;
    logic signed [2*DATA_W-1:0] sprod;
    logic        [2*DATA_W-1:0] uprod;
    logic signed [DATA_W-1:0]   sq;
    logic signed [DATA_W-1:0]   sr;
    logic        [DATA_W-1:0]   uq;
    logic        [DATA_W-1:0]   ur;

    assign sa    = {{DATA_W{a[DATA_W-1]}}, a};
    assign sb    = {{DATA_W{b[DATA_W-1]}}, b};
    assign sprod = sa * sb;
    assign uprod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    // Zero divisor and the single signed overflow case never reach the divider.
    always_comb begin
        sq = '0;
        sr = '0;
        uq = '0;
        ur = '0;
        if (b != '0) begin
            uq = a / b;
            ur = a % b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                sq = $signed(a);
                sr = '0;
            end else begin
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
            end
        end
    end

    always_comb begin
        res = '0;
        dz  = 1'b0;
        case (mdop)
            MD_MULT:  res = sprod;
            MD_MULTU: res = uprod;
            MD_DIV: begin
                res.hi = sr;
                res.lo = sq;
                dz     = (b == '0);
            end
            MD_DIVU: begin
                res.hi = ur;
                res.lo = uq;
                dz     = (b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide controller: fixed-latency busy sequencing, HI/LO ownership and D-stage stall.
module md_scheduler
    import md_scheduler_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    md_scheduler_if.slave md
);

    md_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    md_res_t           pend;
    logic              pend_dz;
    md_op_t            op;
    md_res_t           calc_res;
    logic              calc_dz;

    assign op = md_op_t'(md.MDOp);

    md_calc u_calc (
        .a    (md.A),
        .b    (md.B),
        .mdop (op),
        .res  (calc_res),
        .dz   (calc_dz)
    );

    // Result is computed at issue and parked; the counter only models latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend    <= '0;
            pend_dz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md.Start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                pend    <= calc_res;
                                pend_dz <= 1'b0;
                                cnt     <= CNT_W'(MULT_CYCLES);
                                busy    <= 1'b1;
                                state   <= BUSY;
                            end
                            MD_DIV, MD_DIVU: begin
                                pend    <= calc_res;
                                pend_dz <= calc_dz;
                                cnt     <= CNT_W'(DIV_CYCLES);
                                busy    <= 1'b1;
                                state   <= BUSY;
                            end
                            MD_MTHI: hi <= md.A;
                            MD_MTLO: lo <= md.A;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (!pend_dz) begin
                            hi <= pend.hi;
                            lo <= pend.lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.Busy    = busy;
    assign md.HI      = hi;
    assign md.LO      = lo;
    assign md.MDStall = md.MDInD & (busy | md.Start);
    assign md.MDRes   = (op == MD_MFHI) ? hi : lo;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed self-checking bench for md_scheduler with hand-computed HI/LO and timing.
module tb_md_scheduler;
    import md_scheduler_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    md_scheduler_if mif ();

    md_scheduler #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issuing while busy is illegal; nothing in this bench should ever do it.
    always @(negedge clk) begin
        if (!reset) begin
            assert (!(mif.Start && mif.Busy)) else begin
                errors++;
                $error("FAIL protocol_start_while_busy observed=1 expected=0");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle issue with no busy phase (mthi/mtlo).
    task automatic issue(input logic [2:0] op, input logic [31:0] a);
        mif.MDOp  = op;
        mif.A     = a;
        mif.B     = 32'h0;
        mif.Start = 1'b1;
        next_cycle();
        mif.Start = 1'b0;
    endtask

    // Issue a mult/div, count Busy cycles (bounded) and track MDStall throughout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ind, input int exp_n, input string tag);
        int   n;
        logic stall_ok;
        logic done;
        mif.MDInD = ind;
        mif.MDOp  = op;
        mif.A     = a;
        mif.B     = b;
        mif.Start = 1'b1;
        @(negedge clk);
        chk({tag, "_stall_start"}, 32'(mif.MDStall), 32'(ind));
        next_cycle();
        mif.Start = 1'b0;
        n        = 0;
        stall_ok = 1'b1;
        done     = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mif.Busy) begin
                n++;
                if (mif.MDStall !== ind) stall_ok = 1'b0;
                next_cycle();
            end else begin
                done = 1'b1;
            end
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
        chk({tag, "_stall_after"}, 32'(mif.MDStall), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        mif.Start = 1'b0;
        mif.MDOp  = 3'd0;
        mif.A     = 32'h0;
        mif.B     = 32'h0;
        mif.MDInD = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(mif.Busy), 32'd0);
        chk("rst_hi", mif.HI, 32'h0);
        chk("rst_lo", mif.LO, 32'h0);
        reset = 1'b0;
        next_cycle();

        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 5, "mult");
        chk("mult_hi", mif.HI, 32'hFFFF_FFFF);
        chk("mult_lo", mif.LO, 32'hFFFF_FFFA);
        next_cycle();

        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 5, "multu");
        chk("multu_hi", mif.HI, 32'h0000_0002);
        chk("multu_lo", mif.LO, 32'hFFFF_FFFA);
        next_cycle();

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 10, "div");
        chk("div_hi", mif.HI, 32'hFFFF_FFFF);
        chk("div_lo", mif.LO, 32'hFFFF_FFFD);
        next_cycle();

        run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, 10, "divu");
        mif.MDOp = MD_MFHI;
        #1;
        chk("divu_mfhi_fall_cycle", mif.MDRes, 32'd1);
        mif.MDOp = MD_MFLO;
        #1;
        chk("divu_mflo_fall_cycle", mif.MDRes, 32'd3);
        next_cycle();

        issue(MD_MTHI, 32'h1234_5678);
        chk("mthi_busy", 32'(mif.Busy), 32'd0);
        mif.MDOp = MD_MFHI;
        #1;
        chk("mthi_mfhi", mif.MDRes, 32'h1234_5678);
        chk("mthi_lo_kept", mif.LO, 32'd3);
        issue(MD_MTLO, 32'h9ABC_DEF0);
        chk("mtlo_busy", 32'(mif.Busy), 32'd0);
        mif.MDOp = MD_MFLO;
        #1;
        chk("mtlo_mflo", mif.MDRes, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", mif.HI, 32'h1234_5678);

        issue(MD_MTHI, 32'hAAAA_0000);
        issue(MD_MTLO, 32'h0000_5555);
        run_op(MD_DIV, 32'h0000_1234, 32'h0, 1'b1, 10, "divz");
        chk("divz_hi", mif.HI, 32'hAAAA_0000);
        chk("divz_lo", mif.LO, 32'h0000_5555);
        next_cycle();

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, "divovf");
        chk("divovf_hi", mif.HI, 32'h0);
        chk("divovf_lo", mif.LO, 32'h8000_0000);
        next_cycle();

        // Async reset in the third busy cycle of a mult.
        mif.MDInD = 1'b0;
        mif.MDOp  = MD_MULT;
        mif.A     = 32'd5;
        mif.B     = 32'd7;
        mif.Start = 1'b1;
        next_cycle();
        mif.Start = 1'b0;
        next_cycle();
        next_cycle();
        chk("rstmid_busy_before", 32'(mif.Busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_busy", 32'(mif.Busy), 32'd0);
        chk("rstmid_hi", mif.HI, 32'h0);
        chk("rstmid_lo", mif.LO, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) next_cycle();
        chk("rstmid_after_busy", 32'(mif.Busy), 32'd0);
        chk("rstmid_after_hi", mif.HI, 32'h0);
        chk("rstmid_after_lo", mif.LO, 32'h0);

        run_op(MD_MULT, 32'd5, 32'd7, 1'b1, 5, "post_rst_mult");
        chk("post_rst_hi", mif.HI, 32'h0);
        chk("post_rst_lo", mif.LO, 32'd35);
        mif.MDInD = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
